collect_window_timer: RTL

//   Parametrised collection-window timer. A free-running prescaler produces a 1-cycle tick strobe in the clk50

---
 rtl/collect_timer_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/collect_window_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/collect_timer_pkg.sv
// Shared encodings for the collection-window timer: mode values and window FSM states.
package collect_timer_pkg;

  localparam logic [1:0] MODE_LEVEL    = 2'd0;
  localparam logic [1:0] MODE_WINDOW   = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCollect = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick strobe every PRESCALE_DIV clk50 cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE_DIV = 256
) (
  input  logic clk50,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PhW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(PRESCALE_DIV - 1);

  logic [PhW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + PhW'(1);
    if (phase_q == PhLast) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst || clr) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick = (phase_q == PhLast);

endmodule

// File: rtl/collect_window_timer.sv
// Collection-window timer: tick counter plus a LEVEL/WINDOW/PERIODIC window FSM that gates
// detector collection. collect_time = threshold * PRESCALE_DIV clk50 cycles.
module collect_window_timer
  import collect_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 256,
  parameter int unsigned CNT_W        = 15
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] start_thresh,
  input  logic [CNT_W-1:0] stop_thresh,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             collect_enable,
  output logic             win_open,
  output logic             win_close,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] start_q, stop_q, period_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             coll_q, open_q, close_q;
  logic             open_d, close_d;
  logic             latch;
  logic             periodic_eff;
  logic [CNT_W-1:0] period_eff;

  tick_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk50(clk50),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Shadow registers capture the configuration on IDLE->ARMED; on that same edge the
  // counter must already see the incoming configuration.
  assign latch        = (state_q == StIdle) && enable && !clr;
  assign periodic_eff = latch ? (mode == MODE_PERIODIC) : (mode_q == MODE_PERIODIC);
  assign period_eff   = latch ? period : period_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick && enable) begin
      if (periodic_eff && (count_q == period_eff)) begin
        count_d = '0;
      end else if (count_q != CntMax) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StArmed;
      end
      StArmed: begin
        if (count_q >= start_q) begin
          if (mode_q == MODE_WINDOW) begin
            // Already past stop (including empty windows): finish without opening.
            state_d = (count_q >= stop_q) ? StDone : StCollect;
          end else if (mode_q == MODE_PERIODIC) begin
            if (count_q < stop_q) state_d = StCollect;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (count_q >= stop_q) begin
          if (mode_q == MODE_WINDOW) begin
            state_d = StDone;
          end else if (mode_q == MODE_PERIODIC) begin
            state_d = StArmed;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (clr) state_d = StIdle;
    open_d  = (state_d == StCollect) && (state_q != StCollect);
    close_d = (state_q == StCollect) && (state_d != StCollect) && !clr;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= MODE_LEVEL;
      start_q  <= '0;
      stop_q   <= '0;
      period_q <= '0;
      count_q  <= '0;
      coll_q   <= 1'b0;
      open_q   <= 1'b0;
      close_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      coll_q  <= (state_d == StCollect);
      open_q  <= open_d;
      close_q <= close_d;
      if (latch) begin
        mode_q   <= mode;
        start_q  <= start_thresh;
        stop_q   <= stop_thresh;
        period_q <= period;
      end
    end
  end

  assign count          = count_q;
  assign collect_enable = coll_q;
  assign win_open       = open_q;
  assign win_close      = close_q;
  assign done           = (state_q == StDone);

endmodule
